// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit downstream of the ALU.
// Runs one req/ack transaction on the data-memory bus per start and
// returns sign/zero-extended load data. busy stalls the core while in flight.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               launch (sampled only when idle)
//   mem_read, mem_write operation select (write wins if both set)
//   funct3              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_result          effective byte address
//   store_data          rs2 value
//   busy, done          status; done is a one-cycle completion pulse
//   load_data           extended load result, held until the next done
//   access_fault        misaligned address or illegal funct3 (with done)
//   timeout_err         bus never acknowledged (with done)
//   bus_*               word-addressed memory bus, one-cycle bus_ack
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] load_data_q, load_data_d;
  logic        access_fault_q, access_fault_d;
  logic        timeout_err_q, timeout_err_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_store, is_load, f3_ok, aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Request decode from the live inputs (only used in IDLE).
  always_comb begin
    is_store = mem_write;
    is_load  = mem_read & ~mem_write;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = is_load;
      default:                f3_ok = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   aligned = ~alu_result[0];
      2'b10:   aligned = (alu_result[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Lane select and extension of the returned word using the latched offset.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    load_data_d    = load_data_q;
    access_fault_d = access_fault_q;
    timeout_err_d  = timeout_err_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_be_d       = bus_be_q;
    f3_d           = f3_q;
    off_d          = off_q;
    cnt_d          = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          access_fault_d = 1'b0;
          timeout_err_d  = 1'b0;
          if (!is_store && !is_load) begin
            state_d     = RESP;
            done_d      = 1'b1;
            load_data_d = '0;
          end else if (!f3_ok || !aligned) begin
            state_d        = RESP;
            done_d         = 1'b1;
            access_fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {alu_result[31:2], 2'b00};
            bus_be_d    = is_store ? st_be : 4'b1111;
            bus_wdata_d = is_store ? st_wdata : '0;
            f3_d        = funct3;
            off_d       = alu_result[1:0];
            cnt_d       = '0;
          end
        end
      end
      REQ: begin
        // Ack is checked first so an ack on the final cycle still succeeds.
        if (bus_ack) begin
          state_d   = RESP;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          if (!bus_we_q) load_data_d = rd_ext;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d       = RESP;
          done_d        = 1'b1;
          bus_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      load_data_q    <= '0;
      access_fault_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_be_q       <= '0;
      f3_q           <= '0;
      off_q          <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      load_data_q    <= load_data_d;
      access_fault_q <= access_fault_d;
      timeout_err_q  <= timeout_err_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_be_q       <= bus_be_d;
      f3_q           <= f3_d;
      off_q          <= off_d;
      cnt_q          <= cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign load_data    = load_data_q;
  assign access_fault = access_fault_q;
  assign timeout_err  = timeout_err_q;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit that sits directly downstream of the ALU in the multi-cycle RISC-V core. It takes the ALU result as the effective address and rs2 as store data. It runs a req/ack transaction on the data-memory bus and returns sign- or zero-extended load data to the writeback path. While a transaction is in flight it asserts busy so the control FSM stalls the PC and register writes.

Parameters:
TIMEOUT_CYCLES, 16, REQ-state cycles without bus_ack before the access is aborted (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  sampled only in IDLE; launches the operation given by mem_read/mem_write/funct3
mem_read  in  1  load operation
mem_write  in  1  store operation; has priority over mem_read if both are set
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result  in  32  effective byte address
store_data  in  32  rs2 value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result; valid when done=1 and held until the next done
access_fault  out  1  valid with done: misaligned address or illegal funct3
timeout_err  out  1  valid with done: bus did not acknowledge in time
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_addr  out  32  word address {alu_result[31:2], 2'b00}
bus_wdata  out  32  replicated store data
bus_be  out  4  byte enables
bus_rdata  in  32  read word, valid when bus_ack=1
bus_ack  in  1  one-cycle acknowledge

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Timeout counter 0.
- All outputs are registered. There is no combinational path from input to output.
- States: IDLE, REQ, RESP.
- IDLE, start=1, no op (mem_read=0 and mem_write=0): go to RESP. load_data=0, no flags set.
- IDLE, start=1, fault: go to RESP with access_fault=1. No bus request is issued.
  - Illegal funct3 for a load: 011, 110, 111.
  - Illegal funct3 for a store: anything other than 000, 001, 010.
  - Halfword access with alu_result[0]=1.
  - Word access with alu_result[1:0]!=0.
- IDLE, start=1, legal op: latch address, bus_we, be, wdata, funct3 and byte offset. Go to REQ. bus_req=1 from the next cycle.
- Store byte enables and data:
  - SB: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{store_data[7:0]}}.
  - SH: bus_be = addr[1] ? 4'b1100 : 4'b0011; bus_wdata = {2{store_data[15:0]}}.
  - SW: bus_be = 4'b1111; bus_wdata = store_data.
- Loads drive bus_be=4'b1111.
- REQ: bus_req stays high and all bus outputs are stable until bus_ack.
  - On bus_ack: drop bus_req and go to RESP.
  - Loads: on the same ack, capture the selected byte/half from bus_rdata using the latched offset. Sign-extend for B/H, zero-extend for BU/HU. Stores leave load_data unchanged.
- Timeout: counter increments each REQ cycle without ack. After TIMEOUT_CYCLES such cycles, drop bus_req and go to RESP with timeout_err=1. If ack arrives on the timeout cycle, the ack wins and there is no error.
- RESP: done=1 for exactly one cycle, then IDLE.
  - access_fault and timeout_err are cleared on the next start.
  - busy is high in RESP.
- start while busy is ignored and is not queued.
- bus_ack outside REQ is ignored.
- Best-case latency for a 0-wait bus: start at edge 0, bus_req high during cycle 1, ack sampled at edge 2, done high during cycle 2-3. Total: done 2 cycles after start.

Test Plan:
- SW, addr 0x0000_0010, data 0xDEADBEEF, ack after 3 cycles -> bus_addr=0x10, be=1111, wdata=0xDEADBEEF, bus_we=1. done pulses once. busy high 4+ cycles, access_fault=0.
- LB, addr 0x0000_0023, rdata 0x80FF_1234 -> load_data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH, addr 0x0000_0006, data 0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD. LH at addr 0x0000_0005 -> no bus_req, done with access_fault=1 on the 2nd cycle.
- LW with bus_ack held 0, TIMEOUT_CYCLES=16 -> bus_req high exactly 16 cycles, then done with timeout_err=1. The next legal LW with ack clears timeout_err.
- Assert rst mid-REQ -> bus_req, busy, done go 0 immediately (async). A subsequent ack is ignored. A new start after reset completes normally.
- start pulsed repeatedly during REQ -> only one transaction and one done pulse. mem_read=mem_write=1 with funct3=010 -> executes as SW.
